// File: rtl/uart_ctrl_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_ctrl_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } tx_state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotate-priority picker: first request at or after ptr, wrapping modulo N.
module uart_rr_pick
  import uart_ctrl_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with frame lock sharing one UART byte transmitter
// among N_REQ requesters; drives a held start level and tracks tx_rdy.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int START_HOLD  = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_last,
  input  logic [BYTE_W*N_REQ-1:0]     req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic [BYTE_W-1:0]           tx_data,
  output logic                        tx_start,
  input  logic                        tx_rdy,
  output logic [id_width(N_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int IW = id_width(N_REQ);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] HOLD_END = CW'(START_HOLD - 1);
  localparam logic [CW-1:0] ACK_END  = CW'(ACK_TIMEOUT - 1);

  tx_state_t        state;
  logic             lock;
  logic             last_q;
  logic             seen_low;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    pick_ptr;
  logic [IW-1:0]    pick_idx;
  logic [IW-1:0]    next_ptr;
  logic [N_REQ-1:0] cand;
  logic [N_REQ-1:0] pick_grant;
  logic             pick_any;

  // While locked only the frame owner may compete, so the picker starts at it.
  assign cand     = lock ? (req_valid & (N_REQ'(1) << grant_id)) : req_valid;
  assign pick_ptr = lock ? grant_id : rr_ptr;
  assign next_ptr = (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

  uart_rr_pick #(.N(N_REQ)) u_pick (
    .req   (cand),
    .ptr   (pick_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign busy      = (state != IDLE) || lock;
  assign req_ready = (rst_n && state == IDLE && tx_rdy && pick_any) ? pick_grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      lock        <= 1'b0;
      last_q      <= 1'b0;
      seen_low    <= 1'b0;
      cnt         <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_rdy && pick_any) begin
            tx_data  <= req_data[BYTE_W*int'(pick_idx) +: BYTE_W];
            grant_id <= pick_idx;
            last_q   <= req_last[pick_idx];
            cnt      <= '0;
            seen_low <= 1'b0;
            tx_start <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          cnt <= cnt + 1'b1;
          if (!tx_rdy) seen_low <= 1'b1;
          // A transmitter that already went busy during the hold skips WAIT_BUSY.
          if (cnt == HOLD_END) begin
            tx_start <= 1'b0;
            state    <= (seen_low || !tx_rdy) ? WAIT_DONE : WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          cnt <= cnt + 1'b1;
          if (!tx_rdy) begin
            state <= WAIT_DONE;
          end else if (cnt == ACK_END) begin
            timeout_err <= 1'b1;
            lock        <= 1'b0;
            rr_ptr      <= next_ptr;
            state       <= IDLE;
          end
        end
        WAIT_DONE: begin
          if (tx_rdy) begin
            state <= IDLE;
            if (last_q) begin
              lock   <= 1'b0;
              rr_ptr <= next_ptr;
            end else begin
              lock <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a requester and transmitter model.
module tb_uart_tx_arbiter;
  import uart_ctrl_pkg::*;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_rdy = 1'b1;
  logic [1:0]     grant_id;
  logic           busy;
  logic           timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .START_HOLD(4), .ACK_TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_rdy      (tx_rdy),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  logic [8:0] rq [N][$];
  bit         hold [N];
  int         mode = 0;
  int         busy_delay = 3;
  int         busy_len = 10;

  int         grant_log [$];
  logic [7:0] byte_log [$];
  int         hold_len [$];
  int         unstable = 0, ready_wide = 0, onehot_err = 0, ready_in_busy = 0;
  int         timeout_cnt = 0, timeout_diff = -1;
  int         cyc = 0, rise_cyc = 0, rdy_rise_cyc = 0, busy_fall_cyc = 0, hold_cur = 0;
  logic       start_q = 1'b0, busy_q = 1'b0;
  logic [N-1:0] ready_q = '0;
  logic [7:0] data_q = '0;
  bit         m_act = 0;
  int         m_cnt = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input bit last, input logic [7:0] data);
    rq[idx].push_back({last, data});
  endtask

  task automatic driveReq();
    logic [8:0] h;
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0 && !hold[i]) begin
        h = rq[i][0];
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = h[7:0];
        req_last[i]        = h[8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  // Requester side: a byte is consumed on the edge that closes its ready cycle.
  always begin
    logic [N-1:0] taken;
    @(negedge clk);
    taken = req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (taken[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    driveReq();
  end

  // Monitor first, then the transmitter model reacting to a tx_start rise.
  always @(negedge clk) begin
    cyc++;
    if (req_ready != '0) begin
      if (!$onehot(req_ready)) onehot_err++;
      if (ready_q != '0) ready_wide++;
      if (!tx_rdy) ready_in_busy++;
      for (int i = 0; i < N; i++) if (req_ready[i]) grant_log.push_back(i);
    end
    if (tx_start && !start_q) begin
      byte_log.push_back(tx_data);
      rise_cyc = cyc;
      hold_cur = 0;
    end
    if (tx_start) hold_cur++;
    if (!tx_start && start_q) hold_len.push_back(hold_cur);
    if (tx_data != data_q && !(tx_start && !start_q)) unstable++;
    if (timeout_err) begin
      timeout_cnt++;
      timeout_diff = cyc - rise_cyc;
    end
    if (!busy && busy_q) busy_fall_cyc = cyc;
    if (m_act) begin
      m_cnt++;
      if (m_cnt == busy_delay) tx_rdy = 1'b0;
      else if (m_cnt == busy_delay + busy_len) begin
        tx_rdy = 1'b1;
        rdy_rise_cyc = cyc;
        m_act = 0;
      end
    end
    if (tx_start && !start_q && mode == 0 && !m_act) begin
      m_act = 1;
      m_cnt = 0;
    end
    start_q = tx_start;
    busy_q  = busy;
    ready_q = req_ready;
    data_q  = tx_data;
  end

  function automatic bit queuesEmpty();
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 0;
    return 1;
  endfunction

  function automatic logic [31:0] packGrants();
    logic [31:0] v;
    v = '0;
    foreach (grant_log[k]) v = (v << 4) | 32'(grant_log[k]);
    return v;
  endfunction

  function automatic logic [31:0] packBytes();
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < byte_log.size() && k < 4; k++) v = (v << 8) | 32'(byte_log[k]);
    return v;
  endfunction

  task automatic clearLogs();
    grant_log.delete();
    byte_log.delete();
    hold_len.delete();
    unstable = 0; ready_wide = 0; onehot_err = 0; ready_in_busy = 0;
    timeout_cnt = 0; timeout_diff = -1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    clearLogs();
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n;
    n = 0;
    while (n < budget && !(busy == 1'b0 && tx_rdy == 1'b1 && !m_act && queuesEmpty())) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput({"done_", tag}, 32'(n < budget), 32'd1);
    repeat (3) @(negedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < N; i++) hold[i] = 0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_tx_start", 32'(tx_start), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("rst_grant_id", 32'(grant_id), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_timeout", 32'(timeout_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    clearLogs();

    // Single byte from requester 2 against a slow transmitter.
    busy_len = 100;
    applyStimulus(2, 1'b1, 8'hA5);
    waitDone("single", 400);
    checkOutput("single_grants", packGrants(), 32'h2);
    checkOutput("single_ngrant", 32'(grant_log.size()), 32'd1);
    checkOutput("single_byte", packBytes(), 32'hA5);
    checkOutput("single_hold", 32'(hold_len.size() > 0 ? hold_len[0] : 0), 32'd4);
    checkOutput("single_stable", 32'(unstable), 32'd0);
    checkOutput("single_data_kept", 32'(tx_data), 32'hA5);
    checkOutput("single_busy_fall", 32'(busy_fall_cyc - rdy_rise_cyc >= 1 && busy_fall_cyc - rdy_rise_cyc <= 2), 32'd1);
    checkOutput("single_no_timeout", 32'(timeout_cnt), 32'd0);

    // Wrap: pointer sits at 3, only requester 0 asks.
    busy_len = 10;
    clearLogs();
    applyStimulus(0, 1'b1, 8'h5A);
    waitDone("wrap", 200);
    checkOutput("wrap_grants", packGrants(), 32'h0);
    checkOutput("wrap_byte", packBytes(), 32'h5A);
    clearLogs();
    applyStimulus(0, 1'b1, 8'h01);
    applyStimulus(1, 1'b1, 8'h11);
    waitDone("wrap_ptr", 200);
    checkOutput("wrap_ptr_order", packGrants(), 32'h10);

    // Contention: everyone valid from pointer 0.
    doReset();
    applyStimulus(0, 1'b1, 8'h20);
    applyStimulus(0, 1'b1, 8'h24);
    applyStimulus(1, 1'b1, 8'h21);
    applyStimulus(2, 1'b1, 8'h22);
    applyStimulus(3, 1'b1, 8'h23);
    waitDone("contend", 600);
    checkOutput("contend_order", packGrants(), 32'h01230);
    checkOutput("contend_ngrant", 32'(grant_log.size()), 32'd5);
    checkOutput("contend_bytes", packBytes(), 32'h20212223);
    checkOutput("contend_width", 32'(ready_wide), 32'd0);
    checkOutput("contend_onehot", 32'(onehot_err), 32'd0);

    // Frame lock with the owner stalling mid-frame.
    doReset();
    applyStimulus(0, 1'b0, 8'h10);
    applyStimulus(0, 1'b0, 8'h11);
    applyStimulus(0, 1'b1, 8'h12);
    applyStimulus(1, 1'b1, 8'h40);
    n = 0;
    while (n < 50 && grant_log.size() < 1) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("lock_first_grant", 32'(n < 50), 32'd1);
    hold[0] = 1;
    repeat (50) @(negedge clk);
    #1;
    checkOutput("lock_hold_grants", 32'(grant_log.size()), 32'd1);
    checkOutput("lock_busy", 32'(busy), 32'd1);
    hold[0] = 0;
    waitDone("lock", 400);
    checkOutput("lock_order", packGrants(), 32'h0001);
    checkOutput("lock_bytes", packBytes(), 32'h10111240);

    // Timeout: transmitter never goes busy for requester 1.
    doReset();
    mode = 1;
    applyStimulus(1, 1'b1, 8'h77);
    applyStimulus(2, 1'b1, 8'h88);
    n = 0;
    while (n < 100 && timeout_cnt < 1) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("tmo_seen", 32'(n < 100), 32'd1);
    mode = 0;
    waitDone("tmo", 300);
    checkOutput("tmo_delay", 32'(timeout_diff), 32'd16);
    checkOutput("tmo_pulses", 32'(timeout_cnt), 32'd1);
    checkOutput("tmo_order", packGrants(), 32'h12);
    checkOutput("tmo_bytes", packBytes(), 32'h7788);

    // Reset while the transmitter is mid-byte.
    clearLogs();
    busy_len = 40;
    applyStimulus(0, 1'b1, 8'h99);
    n = 0;
    while (n < 50 && tx_rdy) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("rstmid_busy_seen", 32'(n < 50), 32'd1);
    repeat (6) @(negedge clk);
    applyStimulus(1, 1'b1, 8'h55);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstmid_tx_start", 32'(tx_start), 32'd0);
    checkOutput("rstmid_busy", 32'(busy), 32'd0);
    checkOutput("rstmid_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    waitDone("rstmid", 300);
    checkOutput("rstmid_no_early_ready", 32'(ready_in_busy), 32'd0);
    checkOutput("rstmid_order", packGrants(), 32'h01);
    checkOutput("rstmid_ngrant", 32'(grant_log.size()), 32'd2);

    // Reset during the start hold drops tx_start without a clock edge.
    clearLogs();
    applyStimulus(2, 1'b1, 8'h66);
    n = 0;
    while (n < 50 && !tx_start) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("rststart_seen", 32'(n < 50), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rststart_async", 32'(tx_start), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    waitDone("rststart", 300);
    checkOutput("rststart_ngrant", 32'(grant_log.size()), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
